// File: rtl/retire_tracer_pkg.sv
// ---------------------------------------------------------------------------
// pkg_trace
// Shared types for the retire tracer: the trace record layout, the capture
// FSM state encoding and the default width of the sequence/drop counters.
// The basic address/instruction/data word types live here as well so that
// every file of the tracer uses the same 32-bit definitions.
// ---------------------------------------------------------------------------
package pkg_trace;

    localparam int TRACE_SEQ_W = 16;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;
    typedef logic [31:0] data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } tracer_state_t;

    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        addr_t                  pc;
        instr_t                 instr;
        logic                   rd_we;
        logic [4:0]             rd;
        data_t                  rd_data;
        logic                   mem_we;
        addr_t                  mem_addr;
        data_t                  mem_data;
    } trace_rec_t;

endpackage

// File: rtl/retire_tracer_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Generic synchronous show-ahead FIFO. The head element is presented on
// pop_data whenever the FIFO is not empty, and reads as all-zero otherwise.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is ignored (the caller accounts for the drop).
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   push, push_data      write request and element
//   full                 FIFO holds DEPTH elements
//   pop                  remove head element (ignored while empty)
//   empty, pop_data      head availability and head element
//   level                current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module trace_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0],
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  T            push_data,
    output logic        full,
    input  logic        pop,
    output logic        empty,
    output T            pop_data,
    output logic [AW:0] level
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          do_push, do_pop;

    assign full     = (level_q == FULL_LVL);
    assign empty    = (level_q == '0);
    assign pop_data = empty ? T'('0) : mem_q[rd_ptr_q];
    assign level    = level_q;

    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pop_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/retire_tracer.sv
// ---------------------------------------------------------------------------
// retire_tracer
// Builds one trace record per retired instruction of the multi-cycle core
// and streams the records out through a small show-ahead FIFO.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   instr_start, pc_cur, instruction new instruction latched by the core
//   reg_write, rd, result            register file write of this cycle
//   mem_write, memory_address,
//   memory_data                      data memory store of this cycle
//   retire                           current instruction complete
//   trace_valid, trace_ready,
//   trace_rec                        record stream towards the consumer
//   level                            FIFO occupancy
//   drop_count                       records lost to a full FIFO (saturating)
//   seq_err                          sticky protocol-violation flag
// ---------------------------------------------------------------------------
module retire_tracer
    import pkg_trace::*;
#(
    parameter int DEPTH = 8,
    parameter int SEQ_W = TRACE_SEQ_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     instr_start,
    input  addr_t                    pc_cur,
    input  instr_t                   instruction,
    input  logic                     reg_write,
    input  logic [4:0]               rd,
    input  data_t                    result,
    input  logic                     mem_write,
    input  addr_t                    memory_address,
    input  data_t                    memory_data,
    input  logic                     retire,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output trace_rec_t               trace_rec,
    output logic [$clog2(DEPTH):0]   level,
    output logic [SEQ_W-1:0]         drop_count,
    output logic                     seq_err
);

    localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

    tracer_state_t    state_q,    state_d;
    addr_t            pc_q,       pc_d;
    instr_t           instr_q,    instr_d;
    logic             rd_we_q,    rd_we_d;
    logic [4:0]       rd_q,       rd_d;
    data_t            rd_data_q,  rd_data_d;
    logic             mem_we_q,   mem_we_d;
    addr_t            mem_addr_q, mem_addr_d;
    data_t            mem_data_q, mem_data_d;
    logic [SEQ_W-1:0] seq_q,      seq_d;
    logic [SEQ_W-1:0] drop_q,     drop_d;
    logic             seq_err_q,  seq_err_d;

    logic             rd_hit;
    logic             acc_rd_we;
    logic [4:0]       acc_rd;
    data_t            acc_rd_data;
    logic             acc_mem_we;
    addr_t            acc_mem_addr;
    data_t            acc_mem_data;

    logic             push;
    trace_rec_t       push_rec;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    // Writes to x0 never reach the register file, so they are not traced.
    assign rd_hit = reg_write && (rd != '0);

    // Capture fields as they stand once this cycle's writes are folded in.
    always_comb begin
        acc_rd_we    = rd_we_q;
        acc_rd       = rd_q;
        acc_rd_data  = rd_data_q;
        acc_mem_we   = mem_we_q;
        acc_mem_addr = mem_addr_q;
        acc_mem_data = mem_data_q;
        if (rd_hit) begin
            acc_rd_we   = 1'b1;
            acc_rd      = rd;
            acc_rd_data = result;
        end
        if (mem_write) begin
            acc_mem_we   = 1'b1;
            acc_mem_addr = memory_address;
            acc_mem_data = memory_data;
        end
    end

    // Capture FSM. A write in an instr_start cycle belongs to the new
    // instruction, so the retiring record then uses the stored fields only.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        rd_we_d    = rd_we_q;
        rd_d       = rd_q;
        rd_data_d  = rd_data_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        seq_d      = seq_q;
        seq_err_d  = seq_err_q;
        push       = 1'b0;

        push_rec          = '0;
        push_rec.seq      = TRACE_SEQ_W'(seq_q);
        push_rec.pc       = pc_q;
        push_rec.instr    = instr_q;
        push_rec.rd_we    = instr_start ? rd_we_q    : acc_rd_we;
        push_rec.rd       = instr_start ? rd_q       : acc_rd;
        push_rec.rd_data  = instr_start ? rd_data_q  : acc_rd_data;
        push_rec.mem_we   = instr_start ? mem_we_q   : acc_mem_we;
        push_rec.mem_addr = instr_start ? mem_addr_q : acc_mem_addr;
        push_rec.mem_data = instr_start ? mem_data_q : acc_mem_data;

        unique case (state_q)
            IDLE: begin
                if (!instr_start && retire) begin
                    seq_err_d = 1'b1;
                end
            end
            ACCUM: begin
                if (retire) begin
                    // seq advances even when the push is dropped, leaving a gap.
                    push    = 1'b1;
                    seq_d   = seq_q + SEQ_ONE;
                    state_d = IDLE;
                end else if (instr_start) begin
                    seq_err_d = 1'b1;
                end else begin
                    rd_we_d    = acc_rd_we;
                    rd_d       = acc_rd;
                    rd_data_d  = acc_rd_data;
                    mem_we_d   = acc_mem_we;
                    mem_addr_d = acc_mem_addr;
                    mem_data_d = acc_mem_data;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (instr_start) begin
            state_d    = ACCUM;
            pc_d       = pc_cur;
            instr_d    = instruction;
            rd_we_d    = rd_hit;
            rd_d       = rd_hit ? rd : '0;
            rd_data_d  = rd_hit ? result : '0;
            mem_we_d   = mem_write;
            mem_addr_d = mem_write ? memory_address : '0;
            mem_data_d = mem_write ? memory_data : '0;
        end
    end

    // A push is lost only when the FIFO is full and nothing leaves this cycle.
    always_comb begin
        drop_d = drop_q;
        if (push && fifo_full && !pop && (drop_q != '1)) begin
            drop_d = drop_q + SEQ_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            rd_we_q    <= 1'b0;
            rd_q       <= '0;
            rd_data_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            rd_we_q    <= rd_we_d;
            rd_q       <= rd_d;
            rd_data_q  <= rd_data_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign trace_valid = !fifo_empty;
    assign pop         = trace_valid && trace_ready;
    assign drop_count  = drop_q;
    assign seq_err     = seq_err_q;

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (trace_rec_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_rec),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .pop_data  (trace_rec),
        .level     (level)
    );

endmodule

// File: tb/tb_retire_tracer.sv
// ---------------------------------------------------------------------------
// tb_retire_tracer
// Self-checking bench for retire_tracer. The driver keeps a behavioural
// model of the tracer (instruction in flight, bounded record queue, counters)
// and pushes every record it expects to be emitted into a scoreboard queue.
// An independent monitor pops that queue whenever the DUT hands a record to
// the consumer and compares it.
// ---------------------------------------------------------------------------
module tb_retire_tracer;
    import pkg_trace::*;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             instr_start;
    addr_t            pc_cur;
    instr_t           instruction;
    logic             reg_write;
    logic [4:0]       rd;
    data_t            result;
    logic             mem_write;
    addr_t            memory_address;
    data_t            memory_data;
    logic             retire;
    logic             trace_valid;
    logic             trace_ready;
    trace_rec_t       trace_rec;
    logic [LW-1:0]    level;
    logic [SEQ_W-1:0] drop_count;
    logic             seq_err;

    retire_tracer #(
        .DEPTH (DEPTH),
        .SEQ_W (SEQ_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .instr_start    (instr_start),
        .pc_cur         (pc_cur),
        .instruction    (instruction),
        .reg_write      (reg_write),
        .rd             (rd),
        .result         (result),
        .mem_write      (mem_write),
        .memory_address (memory_address),
        .memory_data    (memory_data),
        .retire         (retire),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_rec      (trace_rec),
        .level          (level),
        .drop_count     (drop_count),
        .seq_err        (seq_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard of records the consumer should receive, in order.
    trace_rec_t exp_q[$];

    // Behavioural model state.
    bit         m_active;
    trace_rec_t m_cur;
    int         m_seq;
    int         m_drop;
    int         m_count;
    bit         m_err;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    // Output-level checks against the model, taken #1 after the clock edge.
    task automatic checkOutput();
        check("trace_valid", 64'(trace_valid), 64'(m_count > 0));
        check("level", 64'(level), 64'(m_count));
        check("drop_count", 64'(drop_count), 64'(m_drop));
        check("seq_err", 64'(seq_err), 64'(m_err));
        if (m_count == 0) begin
            checks++;
            if (trace_rec !== '0) begin
                errors++;
                $display("[TB] FAIL trace_rec_empty: got pc=0x%h seq=%0d, expected all-zero",
                         trace_rec.pc, trace_rec.seq);
            end
        end
    endtask

    // Retire bookkeeping of one clock edge, derived from the tracer's rules:
    // an instruction in flight gathers its latest rd/mem writes and becomes a
    // record on retire; the queue holds at most DEPTH records.
    task automatic modelStep(input logic st, input addr_t pc, input instr_t ins,
                             input logic rw, input logic [4:0] rdi, input data_t res,
                             input logic mw, input addr_t ma, input data_t md,
                             input logic ret, input logic rdy);
        bit         pop_now;
        bit         have_rec;
        trace_rec_t rec;
        pop_now  = (m_count > 0) && rdy;
        have_rec = 0;
        rec      = '0;
        if (ret) begin
            if (m_active) begin
                rec     = m_cur;
                rec.seq = m_seq[15:0];
                if (!st) begin
                    if (rw && rdi != 0) begin
                        rec.rd_we = 1; rec.rd = rdi; rec.rd_data = res;
                    end
                    if (mw) begin
                        rec.mem_we = 1; rec.mem_addr = ma; rec.mem_data = md;
                    end
                end
                have_rec = 1;
                m_seq++;
            end else begin
                m_err = 1;
            end
        end
        if (st) begin
            if (m_active && !ret) m_err = 1;
            m_active    = 1;
            m_cur       = '0;
            m_cur.pc    = pc;
            m_cur.instr = ins;
            if (rw && rdi != 0) begin
                m_cur.rd_we = 1; m_cur.rd = rdi; m_cur.rd_data = res;
            end
            if (mw) begin
                m_cur.mem_we = 1; m_cur.mem_addr = ma; m_cur.mem_data = md;
            end
        end else if (ret) begin
            m_active = 0;
        end else if (m_active) begin
            if (rw && rdi != 0) begin
                m_cur.rd_we = 1; m_cur.rd = rdi; m_cur.rd_data = res;
            end
            if (mw) begin
                m_cur.mem_we = 1; m_cur.mem_addr = ma; m_cur.mem_data = md;
            end
        end
        if (have_rec) begin
            if (m_count < DEPTH || pop_now) begin
                exp_q.push_back(rec);
                m_count++;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        if (pop_now) m_count--;
    endtask

    // One clock cycle: check the state reached so far, then drive new inputs.
    task automatic applyStimulus(input logic st, input addr_t pc, input instr_t ins,
                                 input logic rw, input logic [4:0] rdi, input data_t res,
                                 input logic mw, input addr_t ma, input data_t md,
                                 input logic ret, input logic rdy);
        @(posedge clk);
        #1;
        checkOutput();
        instr_start    = st;
        pc_cur         = pc;
        instruction    = ins;
        reg_write      = rw;
        rd             = rdi;
        result         = res;
        mem_write      = mw;
        memory_address = ma;
        memory_data    = md;
        retire         = ret;
        trace_ready    = rdy;
        modelStep(st, pc, ins, rw, rdi, res, mw, ma, md, ret, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic startInstr(input addr_t pc, input logic rdy);
        applyStimulus(1, pc, $urandom, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic retireInstr(input logic rdy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rdy);
    endtask

    task automatic clearInputs();
        instr_start = 0; pc_cur = 0; instruction = 0; reg_write = 0; rd = 0;
        result = 0; mem_write = 0; memory_address = 0; memory_data = 0;
        retire = 0; trace_ready = 0;
    endtask

    task automatic clearModel();
        m_active = 0; m_cur = '0; m_seq = 0; m_drop = 0; m_count = 0; m_err = 0;
        exp_q.delete();
    endtask

    // Asynchronous reset between edges; its effect is checked immediately.
    task automatic doReset();
        @(posedge clk);
        #1;
        reset_n = 0;
        clearInputs();
        #1;
        check("rst_trace_valid", 64'(trace_valid), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_drop_count", 64'(drop_count), 64'(0));
        check("rst_seq_err", 64'(seq_err), 64'(0));
        clearModel();
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    // Monitor: every accepted record must match the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && trace_valid && trace_ready) begin
            trace_rec_t exp;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL trace_rec_unexpected: got seq=%0d pc=0x%h, expected no record",
                         trace_rec.seq, trace_rec.pc);
            end else begin
                exp = exp_q.pop_front();
                if (trace_rec !== exp) begin
                    errors++;
                    $display("[TB] FAIL trace_rec: got seq=%0d pc=%h ins=%h rd_we=%b rd=%0d rdd=%h mem_we=%b ma=%h md=%h, expected seq=%0d pc=%h ins=%h rd_we=%b rd=%0d rdd=%h mem_we=%b ma=%h md=%h",
                             trace_rec.seq, trace_rec.pc, trace_rec.instr, trace_rec.rd_we, trace_rec.rd,
                             trace_rec.rd_data, trace_rec.mem_we, trace_rec.mem_addr, trace_rec.mem_data,
                             exp.seq, exp.pc, exp.instr, exp.rd_we, exp.rd,
                             exp.rd_data, exp.mem_we, exp.mem_addr, exp.mem_data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 0;
        clearInputs();
        clearModel();
        #1;
        check("init_trace_valid", 64'(trace_valid), 64'(0));
        check("init_level", 64'(level), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        idle(2, 1);

        // Single ADDI
        applyStimulus(1, 32'h0000_0010, 32'h0050_0093, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 5'd1, 32'd5, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3, 1);

        // SW with a write to x0
        applyStimulus(1, 32'h0000_0014, 32'h0020_2023, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 5'd0, 32'h1234_5678, 1, 32'h100, 32'hDEAD_BEEF, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3, 1);

        // Overflow: 10 retires into 8 entries, then a visible seq gap
        doReset();
        for (int i = 0; i < 10; i++) begin
            startInstr(32'h1000 + 32'(4 * i), 0);
            retireInstr(0);
        end
        idle(2, 0);
        idle(DEPTH + 2, 1);
        startInstr(32'h2000, 1);
        retireInstr(1);
        idle(3, 1);

        // Full FIFO with a push and a pop in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            startInstr(32'h3000 + 32'(4 * i), 0);
            retireInstr(0);
        end
        startInstr(32'h3100, 0);
        retireInstr(1);
        idle(2, 0);
        idle(DEPTH + 2, 1);

        // Back-to-back retire and instr_start
        doReset();
        startInstr(32'h4000, 1);
        applyStimulus(0, 0, 0, 1, 5'd3, 32'hAAAA_0001, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h4004, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h200, 32'h5555_0002, 0, 1);
        retireInstr(1);
        idle(3, 1);

        // Protocol errors: retire in IDLE, then a double instr_start
        retireInstr(1);
        startInstr(32'h5000, 1);
        startInstr(32'h5008, 1);
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h0000_0077, 0, 0, 0, 0, 1);
        retireInstr(1);
        idle(3, 1);

        // Reset mid-capture with three records queued
        for (int i = 0; i < 3; i++) begin
            startInstr(32'h6000 + 32'(4 * i), 0);
            retireInstr(0);
        end
        startInstr(32'h6100, 0);
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
        doReset();
        idle(3, 1);

        // Randomized traffic, first with a free consumer, then a slow one
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 800; i++) begin
                logic st, rw, mw, ret, rdy;
                st  = ($urandom_range(0, 99) < 25);
                ret = ($urandom_range(0, 99) < 30);
                rw  = !st && ($urandom_range(0, 99) < 35);
                mw  = !st && ($urandom_range(0, 99) < 20);
                rdy = ($urandom_range(0, 99) < (phase == 0 ? 80 : 25));
                applyStimulus(st, $urandom, $urandom, rw, 5'($urandom_range(0, 31)), $urandom,
                              mw, $urandom, $urandom, ret, rdy);
            end
        end
        idle(DEPTH + 4, 1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
